// File: rtl/imem_prog_loader.sv
// imem_prog_loader: boot-time instruction-memory writer.
// Receives a framed byte stream: MAGIC, LEN_HI, LEN_LO, N x (HI, LO), CSUM.
// It assembles 16-bit words, writes them sequentially from BASE_ADDR, and holds
// the CPU core in reset until the checksum over the length and data bytes matches.
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_rx_data     incoming byte
//   i_rx_valid    i_rx_data is valid
//   o_rx_ready    loader accepts a byte; a transfer is valid & ready at posedge
//   o_imem_we     instruction-memory write strobe, one cycle per word
//   o_imem_addr   instruction-memory word address
//   o_imem_wdata  instruction word
//   o_cpu_reset   active-high reset to the CPU core
//   o_load_done   image loaded and verified (sticky until reset)
//   o_load_error  frame or checksum error (sticky until the next MAGIC)
module imem_prog_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [15:0]       o_imem_wdata,
  output logic              o_cpu_reset,
  output logic              o_load_done,
  output logic              o_load_error
);

  // The counter carries one extra bit so that a full 2^ADDR_W-word image is legal.
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CSUM    = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Registered outputs
  logic              r_rx_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [15:0]       r_imem_wdata;
  logic              r_cpu_reset;
  logic              r_load_done;
  logic              r_load_error;

  // Datapath registers
  logic [7:0]        r_len_hi;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_csum;
  logic [7:0]        r_data_hi;

  // Next values computed by the output process
  logic              w_rx_ready_nx;
  logic              w_imem_we_nx;
  logic [ADDR_W-1:0] w_imem_addr_nx;
  logic [15:0]       w_imem_wdata_nx;
  logic              w_cpu_reset_nx;
  logic              w_load_done_nx;
  logic              w_load_error_nx;
  logic [7:0]        w_len_hi_nx;
  logic [CNT_W-1:0]  w_len_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [7:0]        w_csum_nx;
  logic [7:0]        w_data_hi_nx;

  // Shared decode
  logic              w_xfer;
  logic              w_is_magic;
  logic [15:0]       w_len_rx;
  logic              w_len_zero;
  logic              w_len_oversize;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_last_word;
  logic [ADDR_W-1:0] w_cur_addr;
  logic              w_csum_ok;

  assign w_xfer         = i_rx_valid & r_rx_ready;
  assign w_is_magic     = (i_rx_data == MAGIC);
  assign w_len_rx       = {r_len_hi, i_rx_data};
  assign w_len_zero     = (w_len_rx == 16'd0);
  assign w_len_oversize = (33'(w_len_rx) > MAX_WORDS);
  assign w_cnt_inc      = r_cnt + CNT_W'(1);
  assign w_last_word    = (w_cnt_inc == r_len);
  // Address arithmetic wraps modulo 2^ADDR_W.
  assign w_cur_addr     = ADDR_W'(BASE_ADDR) + r_cnt[ADDR_W-1:0];
  assign w_csum_ok      = (i_rx_data == r_csum);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; every move except the DONE hold needs a byte transfer
  always_comb begin
    w_state_nx = r_state;
    if (w_xfer) begin
      case (r_state)
        S_IDLE:    if (w_is_magic) w_state_nx = S_LEN_HI;
        S_LEN_HI:  w_state_nx = S_LEN_LO;
        S_LEN_LO: begin
          if (w_len_zero)          w_state_nx = S_CSUM;
          else if (w_len_oversize) w_state_nx = S_ERR;
          else                     w_state_nx = S_DATA_HI;
        end
        S_DATA_HI: w_state_nx = S_DATA_LO;
        S_DATA_LO: w_state_nx = w_last_word ? S_CSUM : S_DATA_HI;
        S_CSUM:    w_state_nx = w_csum_ok ? S_DONE : S_ERR;
        S_DONE:    w_state_nx = S_DONE;
        S_ERR:     if (w_is_magic) w_state_nx = S_LEN_HI;
        default:   w_state_nx = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    w_rx_ready_nx   = (w_state_nx != S_DONE);
    w_imem_we_nx    = 1'b0;
    w_imem_addr_nx  = r_imem_addr;
    w_imem_wdata_nx = r_imem_wdata;
    w_cpu_reset_nx  = r_cpu_reset;
    w_load_done_nx  = r_load_done;
    w_load_error_nx = r_load_error;
    w_len_hi_nx     = r_len_hi;
    w_len_nx        = r_len;
    w_cnt_nx        = r_cnt;
    w_csum_nx       = r_csum;
    w_data_hi_nx    = r_data_hi;
    if (w_xfer) begin
      case (r_state)
        S_IDLE, S_ERR: begin
          // A MAGIC byte (re)starts a load; anything else is dropped.
          if (w_is_magic) begin
            w_csum_nx       = 8'h00;
            w_cnt_nx        = '0;
            w_load_error_nx = 1'b0;
          end
        end
        S_LEN_HI: begin
          w_len_hi_nx = i_rx_data;
          w_csum_nx   = r_csum ^ i_rx_data;
        end
        S_LEN_LO: begin
          w_len_nx  = CNT_W'(w_len_rx);
          w_csum_nx = r_csum ^ i_rx_data;
          if (!w_len_zero && w_len_oversize) w_load_error_nx = 1'b1;
        end
        S_DATA_HI: begin
          w_data_hi_nx = i_rx_data;
          w_csum_nx    = r_csum ^ i_rx_data;
        end
        S_DATA_LO: begin
          w_imem_we_nx    = 1'b1;
          w_imem_addr_nx  = w_cur_addr;
          w_imem_wdata_nx = {r_data_hi, i_rx_data};
          w_cnt_nx        = w_cnt_inc;
          w_csum_nx       = r_csum ^ i_rx_data;
        end
        S_CSUM: begin
          if (w_csum_ok) begin
            w_cpu_reset_nx = 1'b0;
            w_load_done_nx = 1'b1;
          end else begin
            w_load_error_nx = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_ready   <= 1'b1;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= ADDR_W'(BASE_ADDR);
      r_imem_wdata <= 16'h0000;
      r_cpu_reset  <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_len_hi     <= 8'h00;
      r_len        <= '0;
      r_cnt        <= '0;
      r_csum       <= 8'h00;
      r_data_hi    <= 8'h00;
    end else begin
      r_rx_ready   <= w_rx_ready_nx;
      r_imem_we    <= w_imem_we_nx;
      r_imem_addr  <= w_imem_addr_nx;
      r_imem_wdata <= w_imem_wdata_nx;
      r_cpu_reset  <= w_cpu_reset_nx;
      r_load_done  <= w_load_done_nx;
      r_load_error <= w_load_error_nx;
      r_len_hi     <= w_len_hi_nx;
      r_len        <= w_len_nx;
      r_cnt        <= w_cnt_nx;
      r_csum       <= w_csum_nx;
      r_data_hi    <= w_data_hi_nx;
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_load_done  = r_load_done;
  assign o_load_error = r_load_error;

endmodule
